// File: rtl/song_pkg.sv
// song_pkg: shared constants, divider table and state encoding for the song player.
package song_pkg;
  localparam logic [8:0] DIV_TABLE [12] = '{
    9'd511, 9'd482, 9'd455, 9'd430, 9'd405, 9'd383,
    9'd361, 9'd341, 9'd322, 9'd303, 9'd286, 9'd270
  };
  localparam logic [7:0] NOTE_REST = 8'h00;
  localparam logic [7:0] NOTE_END  = 8'hFF;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, DONE} state_t;
endpackage

// File: rtl/note_decode.sv
// note_decode: splits a 6-bit note code into octave (code/12) and semitone (code%12).
module note_decode (
  input  logic [5:0] code,
  output logic [2:0] octave,
  output logic [3:0] semitone
);
  assign octave   = 3'(code / 6'd12);
  assign semitone = 4'(code % 6'd12);
endmodule

// File: rtl/song_player.sv
// song_player: sequences note codes from an external ROM into a square-wave speaker output.
module song_player
  import song_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STEP_CYCLES = 4194304,
  parameter int GAP_CYCLES  = 262144,
  parameter int DIV_W       = 9,
  parameter int OCT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              speaker,
  output logic              busy,
  output logic              done
);
  state_t state, state_n;
  logic [2:0] dec_oct, note_oct;
  logic [3:0] dec_semi, note_semi;
  logic note_rest, spk, run, is_end, step_last, addr_last;
  logic [DIV_W-1:0] note_cnt, div;
  logic [OCT_W-1:0] oct_cnt, oct_reload;
  logic [31:0] step_cnt;

  note_decode u_dec (.code(rom_data[5:0]), .octave(dec_oct), .semitone(dec_semi));

  assign div        = DIV_W'(DIV_TABLE[note_semi]) << (DIV_W - 9);
  assign oct_reload = {OCT_W{1'b1}} >> note_oct;
  assign is_end     = rom_data == NOTE_END;
  assign step_last  = step_cnt == STEP_CYCLES - 1;
  assign addr_last  = &rom_addr;
  assign run        = !(pause && state != IDLE);
  assign busy       = state == FETCH || state == LOAD || state == PLAY;
  assign done       = state == DONE;
  // Gating keeps the pin silent in every non-PLAY cycle while pause can still hold it high.
  assign speaker    = spk && state == PLAY;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? FETCH : IDLE;
      FETCH:   state_n = LOAD;
      LOAD:    state_n = !is_end ? PLAY : loop_en ? FETCH : DONE;
      PLAY:    state_n = !step_last ? PLAY : (!addr_last || loop_en) ? FETCH : DONE;
      DONE:    state_n = start ? FETCH : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (reset || stop) begin
      state     <= IDLE;
      rom_addr  <= '0;
      spk       <= 1'b0;
      step_cnt  <= '0;
      note_cnt  <= '0;
      oct_cnt   <= '0;
      note_oct  <= '0;
      note_semi <= '0;
      note_rest <= 1'b0;
    end else if (run) begin
      state <= state_n;
      if (state == PLAY && step_last) rom_addr <= rom_addr + 1'b1;
      else if (state_n == FETCH) rom_addr <= '0;
      if (state == LOAD) begin
        note_oct  <= dec_oct;
        note_semi <= dec_semi;
        note_rest <= rom_data == NOTE_REST;
        step_cnt  <= '0;
        note_cnt  <= '0;
        oct_cnt   <= '0;
        spk       <= 1'b0;
      end else if (state == PLAY) begin
        step_cnt <= step_cnt + 1;
        note_cnt <= note_cnt == '0 ? div : note_cnt - 1'b1;
        if (note_cnt == '0) oct_cnt <= oct_cnt == '0 ? oct_reload : oct_cnt - 1'b1;
        spk <= (note_rest || step_cnt < GAP_CYCLES) ? 1'b0 :
               (note_cnt == '0 && oct_cnt == '0) ? ~spk : spk;
      end
    end
endmodule

// File: tb/tb_song_player.sv
// tb_song_player: directed, table-driven checks of song_player timing, control and tone periods.
module tb_song_player;
  logic clk = 0, reset = 1, start = 0, stop = 0, pause = 0, loop_en = 0, start2 = 0;
  logic [7:0] rom_addr, rom_data, rom_data2;
  logic [1:0] rom_addr2;
  logic speaker, busy, done, speaker2, busy2, done2;
  logic [7:0] rom [256];
  logic [7:0] rom2 [4];
  int total = 0, bad = 0, cyc = 0;
  int done_cnt, done_cyc, max_addr, done2_cnt, done2_cyc, busy2_cnt, held_bad;
  logic prev_spk;
  int tog[$];

  typedef struct {logic [7:0] code; int exp;} vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    rom_data  <= rom[rom_addr];
    rom_data2 <= rom2[rom_addr2];
  end

  song_player #(.STEP_CYCLES(20000), .GAP_CYCLES(1000)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .speaker(speaker), .busy(busy), .done(done));

  song_player #(.ADDR_W(2), .STEP_CYCLES(50), .GAP_CYCLES(10)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .stop(1'b0), .pause(1'b0), .loop_en(1'b0),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .speaker(speaker2), .busy(busy2), .done(done2));

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Toggle offsets are relative to the first PLAY cycle (cycle 3); a flip first seen in cycle c happened at offset c-4.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
    if (speaker !== prev_spk) tog.push_back(cyc - 4);
    prev_spk = speaker;
    if (busy2) busy2_cnt++;
    if (done2) begin done2_cnt++; done2_cyc = cyc; end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    reset = 1; start = 0; stop = 0; pause = 0; start2 = 0;
    tick();
    reset = 0;
    cyc = 0; done_cnt = 0; done_cyc = -1; max_addr = 0;
    done2_cnt = 0; done2_cyc = -1; busy2_cnt = 0;
    tog.delete();
    prev_spk = speaker;
  endtask

  task automatic begin_song();
    do_reset();
    start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    foreach (rom[i]) rom[i] = 8'h00;
    rom2[0] = 8'd60; rom2[1] = 8'd12; rom2[2] = 8'd24; rom2[3] = 8'd1;
    vecs[0] = '{8'hFC, 4096};
    vecs[1] = '{8'd63, 3448};
    vecs[2] = '{8'd50, 7296};
    vecs[3] = '{8'd61, 3864};

    do_reset();
    check("reset_speaker", speaker, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_addr", rom_addr, 0);

    rom[0] = 8'd60; rom[1] = 8'hFF; loop_en = 0;
    begin_song();
    check("start_busy", busy, 1);
    run_to(20010);
    check("basic_toggles", tog.size(), 4);
    for (int i = 0; i < tog.size() && i < 4; i++) check("basic_toggle_at", tog[i], 4096 * (i + 1));
    check("basic_done_cnt", done_cnt, 1);
    check("basic_done_cyc", done_cyc, 20005);
    check("basic_max_addr", max_addr, 1);
    check("basic_busy_end", busy, 0);

    rom[0] = 8'h00;
    begin_song();
    run_to(20010);
    check("rest_toggles", tog.size(), 0);
    check("rest_done_cnt", done_cnt, 1);
    check("rest_done_cyc", done_cyc, 20005);

    rom[0] = 8'd60; loop_en = 1;
    begin_song();
    run_to(24106);
    check("loop_done_cnt", done_cnt, 0);
    check("loop_toggles", tog.size(), 5);
    if (tog.size() >= 5) check("loop_repeat_toggle", tog[4], 24100);
    check("loop_addr", rom_addr, 0);
    check("loop_speaker_high", speaker, 1);
    stop = 1;
    tick();
    stop = 0;
    check("stop_busy", busy, 0);
    check("stop_speaker", speaker, 0);
    loop_en = 0;

    begin_song();
    run_to(4003);
    pause = 1;
    held_bad = 0;
    repeat (500) begin
      tick();
      if (speaker !== 1'b0 || busy !== 1'b1) held_bad++;
    end
    pause = 0;
    check("pause1_held", held_bad, 0);
    run_to(4610);
    check("pause_toggles", tog.size(), 1);
    if (tog.size() >= 1) check("pause_shifted_toggle", tog[0], 4596);
    run_to(4700);
    check("pause2_pre_speaker", speaker, 1);
    pause = 1;
    held_bad = 0;
    repeat (50) begin
      tick();
      if (speaker !== 1'b1) held_bad++;
    end
    check("pause2_held", held_bad, 0);
    check("pause2_no_toggle", tog.size(), 1);
    stop = 1;
    tick();
    stop = 0; pause = 0;
    check("pause_stop_busy", busy, 0);
    check("pause_stop_speaker", speaker, 0);

    for (int v = 0; v < 4; v++) begin
      rom[0] = vecs[v].code; rom[1] = 8'hFF;
      begin_song();
      run_to(vecs[v].exp + 6);
      check($sformatf("vec%0d_toggles", v), tog.size(), 1);
      if (tog.size() >= 1) check($sformatf("vec%0d_first_toggle", v), tog[0], vecs[v].exp);
      check($sformatf("vec%0d_speaker", v), speaker, 1);
      reset = 1;
      tick();
      reset = 0;
      check($sformatf("vec%0d_rst_speaker", v), speaker, 0);
      check($sformatf("vec%0d_rst_busy", v), busy, 0);
      check($sformatf("vec%0d_rst_addr", v), rom_addr, 0);
    end

    do_reset();
    start2 = 1;
    tick();
    start2 = 0;
    run_to(219);
    check("wrap_done_cnt", done2_cnt, 1);
    check("wrap_done_cyc", done2_cyc, 209);
    check("wrap_busy_cycles", busy2_cnt, 208);
    check("wrap_idle_busy", busy2, 0);
    start2 = 1;
    tick();
    start2 = 0;
    run_to(340);
    check("wrap_mid_addr", rom_addr2, 2);
    check("wrap_mid_busy", busy2, 1);
    reset = 1;
    tick();
    reset = 0;
    check("wrap_rst_addr", rom_addr2, 0);
    check("wrap_rst_busy", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/song_player.md
# song_player

Parametrised, restartable single-voice song player. Sequences 8-bit note codes from an external synchronous song ROM, decodes each into octave and semitone, and drives a square-wave `speaker` output. Adds start/stop/pause control, a loop/one-shot mode, an end-of-song marker and a configurable articulation gap. Sits between the game/menu control logic and the audio output pin, replacing the free-running tune generator.

## Interface
- `ADDR_W`, 8: song ROM address width; song length up to 2^ADDR_W entries.
- `STEP_CYCLES`, 4194304: clock cycles per ROM entry (tempo).
- `GAP_CYCLES`, 262144: silent cycles at the start of every step; must be less than `STEP_CYCLES`.
- `DIV_W`, 9: semitone divider width, at least 9; package table values shifted left by `DIV_W-9`.
- `OCT_W`, 8: octave counter width; reload value is `(2^OCT_W-1) >> octave`.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: level sampled in IDLE/DONE; begins playback from address 0.
- `stop` input 1: abort from any state to IDLE; priority over all other inputs except `reset`.
- `pause` input 1: while high, every counter and the state are frozen and `speaker` holds its value.
- `loop_en` input 1: at song end, 1 restarts at address 0; 0 finishes.
- `rom_addr` output ADDR_W: registered ROM address.
- `rom_data` input 8: ROM output, valid one cycle after `rom_addr`.
- `speaker` output 1: square-wave audio.
- `busy` output 1: high in FETCH, LOAD and PLAY.
- `done` output 1: one-cycle pulse on one-shot completion.

## Operation
- Note code: `rom_data[5:0]` = octave*12 + semitone, with octave = code/12 (0..5) and semitone = code%12. 8'h00 is a rest. 8'hFF is end-of-song. Bits [7:6] are otherwise ignored.
- Semitone divider table (A..G#): 511, 482, 455, 430, 405, 383, 361, 341, 322, 303, 286, 270.
- State machine:
  - IDLE --start--> FETCH. Address set to 0.
  - FETCH -> LOAD. `rom_addr` is stable and the ROM reads it.
  - LOAD: latch `rom_data`. If 8'hFF: go to FETCH at address 0 when `loop_en`=1, otherwise go to DONE. Otherwise clear the note, octave and step counters and go to PLAY.
  - PLAY: the step counter runs 0..STEP_CYCLES-1. On the terminal count, increment the address. If the address wraps from 2^ADDR_W-1 to 0, treat it as end-of-song (same rule as 8'hFF); otherwise go to FETCH.
  - DONE: pulse `done`, then go to IDLE. `start` sampled in DONE goes directly to FETCH.
- Tone generation in PLAY:
  - The note counter reloads with the divider value on 0 and decrements otherwise.
  - The octave counter steps only when the note counter is 0.
  - `speaker` toggles when both counters are 0, the step counter is at or above `GAP_CYCLES`, and the note is not a rest.
  - During the gap or a rest, `speaker` is forced to 0. The counters keep running.
- Outside PLAY, `speaker` = 0.
- `stop` and `reset`: next state IDLE, `speaker`=0, address=0, `done`=0.
- `pause` has no effect in IDLE. A `stop` during pause takes effect.

## Timing
- Reset values: `speaker`=0, `busy`=0, `done`=0, `rom_addr`=0, state IDLE, all counters 0.
- Start latency: `start` high in cycle 0 → FETCH in cycle 1 → LOAD in cycle 2 → PLAY in cycle 3 (step count 0).
- Each note occupies STEP_CYCLES + 2 cycles (FETCH + LOAD overhead).
- Speaker half-period = (divider<<(DIV_W-9) + 1) × (octave reload + 1) cycles. Example: code 60 (octave 5, A) at defaults gives 512×8 = 4096.
- `done` is asserted for exactly the cycle the state is DONE. `busy` falls in that same cycle.
- Pause freezes the machine with cycle accuracy: on release it resumes on the exact cycle count it paused at.

## Structure
- Package `song_pkg` holds:
  - the semitone divider table constant;
  - the `NOTE_REST` (8'h00) and `NOTE_END` (8'hFF) constants;
  - the state enum (IDLE, FETCH, LOAD, PLAY, DONE).
- Sub-module `note_decode`: combinational 6-bit code → 3-bit octave, 4-bit semitone (divide-by-12). It is registered in LOAD by the parent.
- The ROM is external; the bench supplies a one-cycle-latency model.

## Test plan
- Reset mid-PLAY (`STEP_CYCLES`=20000, `GAP_CYCLES`=1000, ROM[0]=60) → next cycle `speaker`=0, `busy`=0, `rom_addr`=0.
- ROM[0]=60, ROM[1]=8'hFF, `loop_en`=0, pulse `start` at cycle 0:
  - PLAY is entered at cycle 3;
  - `speaker` toggles at PLAY offsets 4096, 8192, 12288, 16384, but not at offset 0 (gap);
  - `done` pulses exactly once, at cycle 3 + 20000 + 2;
  - `rom_addr` never exceeds 1.
- ROM[0]=0 (rest), ROM[1]=8'hFF → `speaker` stays 0 for the whole step, then `done`.
- Same song with `loop_en`=1 → no `done`; `rom_addr` returns to 0 and the note-60 step repeats; `stop` then gives IDLE and `speaker`=0 on the next cycle.
- `pause` high for 500 cycles starting at PLAY offset 4000 → the first toggle moves from offset 4096 to offset 4596; `speaker` is held throughout the pause.
- `ADDR_W`=2 with no 8'hFF in ROM[0..3], `loop_en`=0 → four steps play, the address wrap triggers `done`, and the ROM is never read a fifth time.
